// File: rtl/instruction_fetch.sv
// Fetch stage: owns the architectural PC, reads instruction memory over req/ack and
// holds one fetched instruction for decode. Handles redirect (flush) and halt.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] last_pc,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted
);

    // state  | meaning
    // FETCH  | request outstanding at imem_addr; drop=1 means its data is discarded
    // VALID  | if_instr/if_pc held for decode
    // HALTED | fetch stopped until reset
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] issue_pc, issue_pc_nxt;
    logic        drop, drop_nxt;
    logic [31:0] if_pc_nxt, if_instr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            issue_pc <= RESET_PC;
            drop     <= 1'b0;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            issue_pc <= issue_pc_nxt;
            drop     <= drop_nxt;
            if_pc    <= if_pc_nxt;
            if_instr <= if_instr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        issue_pc_nxt = issue_pc;
        drop_nxt     = drop;
        if_pc_nxt    = if_pc;
        if_instr_nxt = if_instr;
        case (state)
            FETCH: begin
                // issue_pc freezes the in-flight address once a flush retargets pc
                if (!drop) issue_pc_nxt = pc;
                if (flush) begin
                    pc_nxt   = flush_pc;
                    drop_nxt = !imem_ack;
                end else if (imem_ack) begin
                    if (drop) begin
                        drop_nxt = 1'b0;
                    end else begin
                        if_instr_nxt = imem_rdata;
                        if_pc_nxt    = pc;
                        state_nxt    = VALID;
                    end
                end
            end
            VALID: begin
                if (flush) begin
                    pc_nxt    = flush_pc;
                    state_nxt = FETCH;
                end else if (if_ready) begin
                    if (halt) begin
                        state_nxt = HALTED;
                    end else begin
                        pc_nxt    = next_pc;
                        state_nxt = FETCH;
                    end
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // rst_n gate keeps the request low while reset is asserted
    assign imem_req  = (state == FETCH) && rst_n;
    assign imem_addr = drop ? issue_pc : pc;
    assign if_valid  = (state == VALID);
    assign halted    = (state == HALTED);
    assign last_pc   = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, delayed-ack flush,
// flush vs accept, halt, mid-wait reset and flush coincident with ack.
module tb_instruction_fetch;

    localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] last_pc;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;

    int tests  = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .last_pc    (last_pc),
        .next_pc    (next_pc),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .halted     (halted)
    );

    // memory returns a word derived from its address; pc_calculator simply increments
    assign imem_rdata = imem_addr ^ MEM_XOR;
    assign next_pc    = last_pc + 32'd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        if_ready = 1'b0;
        flush    = 1'b0;
        flush_pc = 32'h0;
        halt     = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", last_pc, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 0);

        // zero-wait memory, decode always ready: one instruction per two cycles
        imem_ack = 1'b1;
        if_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("seq_req%0d", k), imem_req, 1);
            check($sformatf("seq_addr%0d", k), imem_addr, k);
            check($sformatf("seq_fetch_novalid%0d", k), if_valid, 0);
            step();
            check($sformatf("seq_valid%0d", k), if_valid, 1);
            check($sformatf("seq_if_pc%0d", k), if_pc, k);
            check($sformatf("seq_instr%0d", k), if_instr, k ^ MEM_XOR);
            check($sformatf("seq_req_low%0d", k), imem_req, 0);
            step();
        end
        check("seq_end_pc", last_pc, 4);

        // ack delayed 3 cycles at pc=4 with a flush to 0x40 in between
        imem_ack = 1'b0;
        step();
        check("dly_addr0", imem_addr, 4);
        flush    = 1'b1;
        flush_pc = 32'h40;
        step();
        flush = 1'b0;
        check("dly_addr_held", imem_addr, 4);
        check("dly_pc_redirect", last_pc, 32'h40);
        check("dly_req", imem_req, 1);
        check("dly_novalid", if_valid, 0);
        step();
        check("dly_addr_held2", imem_addr, 4);
        imem_ack = 1'b1;
        if_ready = 1'b0;
        step();
        check("dly_discard", if_valid, 0);
        check("dly_new_addr", imem_addr, 32'h40);
        check("dly_new_req", imem_req, 1);
        step();
        check("dly_valid", if_valid, 1);
        check("dly_if_pc", if_pc, 32'h40);
        check("dly_instr", if_instr, 32'h40 ^ MEM_XOR);

        // decode stalls for 5 cycles
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("stall_valid%0d", c), if_valid, 1);
            check($sformatf("stall_if_pc%0d", c), if_pc, 32'h40);
            check($sformatf("stall_instr%0d", c), if_instr, 32'h40 ^ MEM_XOR);
            check($sformatf("stall_req%0d", c), imem_req, 0);
            check($sformatf("stall_pc%0d", c), last_pc, 32'h40);
        end

        // flush beats a simultaneous accept
        if_ready = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h7;
        step();
        flush = 1'b0;
        check("fva_valid", if_valid, 0);
        check("fva_pc", last_pc, 32'h7);
        check("fva_addr", imem_addr, 32'h7);
        check("fva_req", imem_req, 1);
        step();
        check("halt_pre_valid", if_valid, 1);
        check("halt_pre_if_pc", if_pc, 32'h7);

        // accept with halt at pc=7
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_halted", halted, 1);
        check("halt_req", imem_req, 0);
        check("halt_valid", if_valid, 0);
        check("halt_pc", last_pc, 32'h7);
        flush    = 1'b1;
        flush_pc = 32'h200;
        step();
        flush = 1'b0;
        check("halt_flush_ign", halted, 1);
        check("halt_flush_pc", last_pc, 32'h7);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("halt_req_low%0d", c), imem_req, 0);
        end

        // reset out of halt, then async reset while a redirected request waits
        rst_n = 1'b0;
        #1;
        check("rst2_halted", halted, 0);
        step();
        rst_n    = 1'b1;
        imem_ack = 1'b0;
        step();
        flush    = 1'b1;
        flush_pc = 32'h55;
        step();
        flush = 1'b0;
        check("mid_pc", last_pc, 32'h55);
        check("mid_addr", imem_addr, 0);
        check("mid_req", imem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_pc", last_pc, 0);
        check("mid_rst_valid", if_valid, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("mid_rel_addr", imem_addr, 0);
        check("mid_rel_req", imem_req, 1);

        // flush in the same cycle as the ack: data discarded, no drop pending
        imem_ack = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h30;
        step();
        flush    = 1'b0;
        imem_ack = 1'b0;
        check("fack_valid", if_valid, 0);
        check("fack_pc", last_pc, 32'h30);
        check("fack_addr", imem_addr, 32'h30);
        imem_ack = 1'b1;
        step();
        check("fack_next_valid", if_valid, 1);
        check("fack_next_if_pc", if_pc, 32'h30);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
